// File: rtl/uart_fifo_arbiter_pkg.sv
// Shared types for the UART TX fifo arbiter: controller state encoding.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_fifo_arbiter_if.sv
// Bundle of producer streams, fifo push side and flush/grant status for the arbiter.
interface uart_fifo_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ-1:0]            REQ_LAST;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic                          FIFO_FULL;
    logic                          FIFO_PUSH;
    logic [DATA_WIDTH-1:0]         FIFO_DATA;
    logic                          FIFO_FLUSH;
    logic                          FLUSH_REQ;
    logic                          FLUSH_DONE;
    logic                          GRANT_VALID;
    logic [ID_W-1:0]               GRANT_ID;

    modport slave (
        input  REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL, FLUSH_REQ,
        output REQ_READY, FIFO_PUSH, FIFO_DATA, FIFO_FLUSH, FLUSH_DONE,
               GRANT_VALID, GRANT_ID
    );

    modport master (
        output REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL, FLUSH_REQ,
        input  REQ_READY, FIFO_PUSH, FIFO_DATA, FIFO_FLUSH, FLUSH_DONE,
               GRANT_VALID, GRANT_ID
    );
endinterface

// File: rtl/uart_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap so non-power-of-2 NUM_REQ never indexes past the last requester
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end
endmodule

// File: rtl/uart_fifo_arbiter.sv
// Round-robin sharing of one UART TX fifo push port with bounded bursts and flush sequencing.
module uart_fifo_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic                CLK,
    input logic                RESET_N,
    uart_fifo_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  flush_q, flush_d;
    logic                  done_q, done_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  granted, accept, rel_grant;
    logic [CNT_W-1:0]      cnt_inc;
    logic [NUM_REQ-1:0]    ready_vec;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.REQ_VALID),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (id_q == ID_W'(k)) begin
                sel_valid = bus.REQ_VALID[k];
                sel_last  = bus.REQ_LAST[k];
                sel_data  = bus.REQ_DATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        // Handshake is gated by RESET_N so the reset cycle never pushes an abandoned beat
        granted   = (state_q == ST_GRANT) && RESET_N;
        accept    = granted && sel_valid && !bus.FIFO_FULL;
        cnt_inc   = cnt_q + CNT_W'(1);
        rel_grant = !sel_valid || (accept && (sel_last || cnt_inc == CNT_W'(MAX_BURST)));
        ready_vec = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (granted && !bus.FIFO_FULL && id_q == ID_W'(k)) ready_vec[k] = 1'b1;
        end

        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.FLUSH_REQ) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b1;
                end else if (pick_found) begin
                    state_d = ST_GRANT;
                    id_d    = pick_idx;
                end
            end
            ST_GRANT: begin
                if (accept) cnt_d = cnt_inc;
                if (rel_grant) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    assign bus.REQ_READY   = ready_vec;
    assign bus.FIFO_PUSH   = accept;
    assign bus.FIFO_DATA   = granted ? sel_data : '0;
    assign bus.FIFO_FLUSH  = flush_q;
    assign bus.FLUSH_DONE  = done_q;
    assign bus.GRANT_VALID = (state_q == ST_GRANT);
    assign bus.GRANT_ID    = id_q;
endmodule
